plru_array: RTL and testbench

- Parametrised tree pseudo-LRU (PLRU) replacement unit for the set-associative caches.
- Holds one (NUM_WAYS-1)-bit tree state per set in flops and serves victim queries with registered responses.
- Accepts hit/fill touch updates and prefers invalid ways on replacement.
- Provides a sequenced flush that resets all sets. Sits beside the tag/valid arrays in the cache datapath; the cache controller drives it.

---
 rtl/plru_array_if.sv | 30 +++
 rtl/plru_array.sv | 125 ++++++++++++
 tb/tb_plru_array.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/plru_array_if.sv
// Controller-facing bundle of the PLRU replacement unit: victim query/response,
// touch updates, flush request and ready.
interface plru_array_if #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);

    logic                req_valid;
    logic [SET_W-1:0]    req_set;
    logic [NUM_WAYS-1:0] req_valid_mask;
    logic                rsp_valid;
    logic [NUM_WAYS-1:0] rsp_way_oh;
    logic [WAY_W-1:0]    rsp_way_idx;
    logic                upd_valid;
    logic [SET_W-1:0]    upd_set;
    logic [WAY_W-1:0]    upd_way;
    logic                flush;
    logic                ready;

    modport master (
        output req_valid, req_set, req_valid_mask, upd_valid, upd_set, upd_way, flush,
        input  rsp_valid, rsp_way_oh, rsp_way_idx, ready
    );
    modport slave (
        input  req_valid, req_set, req_valid_mask, upd_valid, upd_set, upd_way, flush,
        output rsp_valid, rsp_way_oh, rsp_way_idx, ready
    );
endinterface

// File: rtl/plru_array.sv
// Tree pseudo-LRU state per cache set: registered victim queries with
// invalid-way preference, hit/fill touches, and a one-set-per-cycle flush.
module plru_array #(
    parameter  int NUM_WAYS = 4,
    parameter  int NUM_SETS = 16,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int SET_W    = $clog2(NUM_SETS)
) (
    input  logic        clk,
    input  logic        rst,
    plru_array_if.slave bus
);
    localparam int NODES = NUM_WAYS - 1;

    generate
        if (NUM_WAYS < 2 || NUM_WAYS > 16 || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
            $fatal(1, "plru_array: NUM_WAYS must be a power of 2 in 2..16");
        end
        if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_sets
            $fatal(1, "plru_array: NUM_SETS must be a power of 2 and >= 2");
        end
    endgenerate

    typedef logic [NODES-1:0] tree_t;
    typedef enum logic {IDLE, FLUSH} state_t;

    // Heap-numbered tree: way w is leaf w+NODES; a left child is odd, so the
    // parent must point right (1) to steer away from it.
    function automatic tree_t touch(tree_t t, logic [WAY_W-1:0] w);
        tree_t r;
        int    n;
        r = t;
        n = int'(w) + NODES;
        for (int l = 0; l < WAY_W; l++) begin
            r[(n - 1) / 2] = n[0];
            n = (n - 1) / 2;
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] walk(tree_t t);
        int n;
        n = 0;
        for (int l = 0; l < WAY_W; l++) n = 2 * n + (t[n] ? 2 : 1);
        return WAY_W'(n - NODES);
    endfunction

    function automatic logic [WAY_W-1:0] first_zero(logic [NUM_WAYS-1:0] m);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) if (!m[i]) r = WAY_W'(i);
        return r;
    endfunction

    state_t                       state, state_n;
    logic   [SET_W-1:0]           cnt, cnt_n;
    logic                         clr, ready;
    logic                         q_acc, upd_acc;
    logic   [NUM_SETS-1:0][NODES-1:0] tree;
    tree_t                        cur;
    logic   [WAY_W-1:0]           vic;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clr     = 1'b0;
        ready   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.flush) begin
                    state_n = FLUSH;
                    cnt_n   = '0;
                end
            end
            FLUSH: begin
                clr   = 1'b1;
                cnt_n = cnt + 1'b1;
                if (cnt == SET_W'(NUM_SETS - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ready = ready;
    assign q_acc     = ready & bus.req_valid;
    assign upd_acc   = ready & bus.upd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tree <= '0;
        else if (clr)     tree[cnt] <= '0;
        else if (upd_acc) tree[bus.upd_set] <= touch(tree[bus.upd_set], bus.upd_way);
    end

    // A same-set touch in the query cycle is forwarded so the query sees it.
    always_comb begin
        cur = tree[bus.req_set];
        if (upd_acc && bus.upd_set == bus.req_set) cur = touch(cur, bus.upd_way);
        vic = (&bus.req_valid_mask) ? walk(cur) : first_zero(bus.req_valid_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_way_oh  <= '0;
            bus.rsp_way_idx <= '0;
        end else begin
            bus.rsp_valid <= q_acc;
            if (q_acc) begin
                bus.rsp_way_idx <= vic;
                bus.rsp_way_oh  <= NUM_WAYS'(1) << vic;
            end
        end
    end
endmodule

// File: tb/tb_plru_array.sv
// Bench for plru_array: 4-, 8- and 2-way instances share one stimulus stream and
// are checked against a last-touch-timestamp PLRU model.
module tb_plru_array;
    localparam int NS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv, uv, fl;
    logic [3:0]  rs, us, uway;
    logic [15:0] mask16;

    logic        rsp_v   [3];
    logic [15:0] rsp_oh  [3];
    logic [3:0]  rsp_idx [3];
    logic        rdy     [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 2;
        plru_array_if #(.NUM_WAYS(W), .NUM_SETS(NS)) bus ();
        assign bus.req_valid      = rv;
        assign bus.req_set        = rs;
        assign bus.req_valid_mask = mask16[W-1:0];
        assign bus.upd_valid      = uv;
        assign bus.upd_set        = us;
        assign bus.upd_way        = uway[$clog2(W)-1:0];
        assign bus.flush          = fl;
        assign rsp_v[g]   = bus.rsp_valid;
        assign rsp_oh[g]  = 16'(bus.rsp_way_oh);
        assign rsp_idx[g] = 4'(bus.rsp_way_idx);
        assign rdy[g]     = bus.ready;
        plru_array #(.NUM_WAYS(W), .NUM_SETS(NS)) dut (.clk(clk), .rst(rst), .bus(bus));
    end

    typedef struct {
        logic v;
        int   idx;
        logic rdy;
        int   lit;
    } exp_t;

    int unsigned stamp [3][NS][16];
    int unsigned tnow;
    int          busy;
    exp_t        exp_c [3];
    exp_t        exp_p [3];
    int          n_cmp = 0;
    int          n_bad = 0;
    event        rst_ev;

    function automatic int ways(int i);
        return (i == 0) ? 4 : (i == 1) ? 8 : 2;
    endfunction

    function automatic exp_t exp_rst();
        exp_t e;
        e.v = 1'b0; e.idx = 0; e.rdy = 1'b1; e.lit = -1;
        return e;
    endfunction

    // Each tree node points away from the most recently touched leaf beneath
    // it, or left when nothing beneath it was touched since the last clear.
    function automatic int model_victim(int i, int s, logic [15:0] m);
        int          w, lo, sz, half, inv;
        int unsigned ml, mr;
        w = ways(i); lo = 0; sz = w; inv = -1;
        for (int j = w - 1; j >= 0; j--) if (!m[j]) inv = j;
        if (inv >= 0) return inv;
        while (sz > 1) begin
            half = sz / 2; ml = 0; mr = 0;
            for (int j = lo; j < lo + half; j++)      if (stamp[i][s][j] > ml) ml = stamp[i][s][j];
            for (int j = lo + half; j < lo + sz; j++) if (stamp[i][s][j] > mr) mr = stamp[i][s][j];
            if (ml > mr) lo += half;
            sz = half;
        end
        return lo;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++)
            for (int s = 0; s < NS; s++)
                for (int j = 0; j < 16; j++) stamp[i][s][j] = 0;
        busy = 0;
        for (int i = 0; i < 3; i++) begin
            exp_c[i] = exp_rst();
            exp_p[i] = exp_rst();
        end
    endtask

    task automatic model_step(int l0, int l1, int l2);
        logic acc;
        acc = (busy == 0);
        for (int i = 0; i < 3; i++) begin
            if (acc && uv) begin
                tnow++;
                stamp[i][us][int'(uway) % ways(i)] = tnow;
            end
            exp_p[i].v = acc && rv;
            if (acc && rv) exp_p[i].idx = model_victim(i, int'(rs), mask16);
            if (acc && fl)
                for (int s = 0; s < NS; s++)
                    for (int j = 0; j < 16; j++) stamp[i][s][j] = 0;
            exp_p[i].lit = (i == 0) ? l0 : (i == 1) ? l1 : l2;
        end
        if (acc && fl)     busy = NS;
        else if (busy > 0) busy--;
        for (int i = 0; i < 3; i++) exp_p[i].rdy = (busy == 0);
    endtask

    // Inputs are already driven (1 ns after a posedge); advance one cycle.
    task automatic step(int l0 = -1, int l1 = -1, int l2 = -1);
        model_step(l0, l1, l2);
        @(posedge clk); #1;
        exp_c = exp_p;
    endtask

    task automatic idle();
        rv = 1'b0; uv = 1'b0; fl = 1'b0;
        rs = '0; us = '0; uway = '0; mask16 = '1;
    endtask

    task automatic randin();
        rv     = 1'($urandom_range(1));
        rs     = 4'($urandom_range(15));
        mask16 = ($urandom_range(3) == 0) ? 16'($urandom) : 16'hFFFF;
        uv     = 1'($urandom_range(1));
        us     = ($urandom_range(2) == 0) ? rs : 4'($urandom_range(15));
        uway   = 4'($urandom_range(15));
        fl     = ($urandom_range(59) == 0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1 -> rst_ev;
        repeat (2) @(posedge clk);
        #1;
        idle();
        rst = 1'b0;
    endtask

    task automatic all_sets_way0();
        for (int s = 0; s < NS; s++) begin
            idle(); rv = 1'b1; rs = 4'(s);
            step(0, 0, 0);
        end
    endtask

    function automatic void cmp(string nm, int i, logic [31:0] act, logic [31:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0h, expected %0h", nm, i, act, ex);
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk or rst_ev);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    cmp("rst_ready", i, 32'(rdy[i]), 32'd1);
                    cmp("rst_rsp_valid", i, 32'(rsp_v[i]), 32'd0);
                    cmp("rst_oh", i, 32'(rsp_oh[i]), 32'd0);
                    cmp("rst_idx", i, 32'(rsp_idx[i]), 32'd0);
                end else begin
                    cmp("ready", i, 32'(rdy[i]), 32'(exp_c[i].rdy));
                    cmp("rsp_valid", i, 32'(rsp_v[i]), 32'(exp_c[i].v));
                    if (exp_c[i].v) begin
                        cmp("way_idx", i, 32'(rsp_idx[i]), 32'(exp_c[i].idx));
                        cmp("way_oh", i, 32'(rsp_oh[i]), 32'd1 << exp_c[i].idx);
                    end
                    if (exp_c[i].lit >= 0) begin
                        cmp("lit_valid", i, 32'(rsp_v[i]), 32'd1);
                        cmp("lit_idx", i, 32'(rsp_idx[i]), 32'(exp_c[i].lit));
                    end
                end
            end
        end
    end

    initial begin
        tnow = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        idle(); rv = 1'b1; rs = 4'd3;                            step(0, 0, 0);
        idle(); uv = 1'b1; us = 4'd5; uway = 4'd0;               step();
        idle(); rv = 1'b1; rs = 4'd5;                            step(2, 4, 1);
        idle(); uv = 1'b1; us = 4'd5; uway = 4'd2;               step();
        idle(); rv = 1'b1; rs = 4'd5;                            step(1, 4, 1);
        idle(); rv = 1'b1; rs = 4'd5; mask16 = 16'hFFFB;         step(2, 2, 1);
        idle(); uv = 1'b1; us = 4'd7; uway = 4'd0; rv = 1'b1; rs = 4'd7; step(2, 4, 1);
        idle(); uv = 1'b1; us = 4'd6; uway = 4'd0; rv = 1'b1; rs = 4'd8; step(0, 0, 0);
        idle(); rv = 1'b1; rs = 4'd7;                            step(2, 4, 1);
        idle(); uv = 1'b1; us = 4'd9; uway = 4'd0;               step();
        idle(); uv = 1'b1; us = 4'd9; uway = 4'd5;               step();
        idle(); rv = 1'b1; rs = 4'd9;                            step(2, 2, 0);

        // flush with a same-cycle query and update, then traffic while busy
        idle(); fl = 1'b1; rv = 1'b1; rs = 4'd9; uv = 1'b1; us = 4'd9; uway = 4'd3;
        step();
        for (int k = 0; k < NS; k++) begin
            randin(); rv = 1'b1; uv = 1'b1;
            step();
        end
        all_sets_way0();

        // reset with a response pending
        for (int k = 0; k < 6; k++) begin idle(); uv = 1'b1; us = 4'(k); uway = 4'(k); step(); end
        idle(); rv = 1'b1; rs = 4'd2; step();
        do_reset();
        all_sets_way0();

        // reset in the middle of a flush
        for (int k = 0; k < 6; k++) begin idle(); uv = 1'b1; us = 4'(k + 4); uway = 4'(k + 1); step(); end
        idle(); fl = 1'b1; step();
        for (int k = 0; k < 5; k++) begin randin(); step(); end
        do_reset();
        all_sets_way0();

        for (int k = 0; k < 2000; k++) begin
            randin();
            if ($urandom_range(399) == 0) do_reset();
            else step();
        end
        idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
